// File: rtl/hb_interp2_if.sv
// Sample handshake bundle for hb_interp2: valid/ready input stream and valid/ready output stream.
interface hb_interp2_if;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;

    // slave is the interpolator's view; master is the producer/consumer around it.
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
endinterface

// File: rtl/hb_interp2.sv
// Half-band x2 interpolator on one time-shared 17x16 multiplier; A result 8 clocks after accept, output held under backpressure.
// HB_INTERP_SAT_EN: clamp branch A to 16 bits and expose sticky sat_flag; otherwise branch A wraps.
module hb_interp2 (
    input  logic        clk,
    input  logic        reset,
    hb_interp2_if.slave bus
`ifdef HB_INTERP_SAT_EN
    ,
    output logic        sat_flag
`endif
);
    typedef enum logic [1:0] {IDLE, MAC, OUT_A, OUT_B} state_t;

    state_t             state, state_nxt;
    logic signed [15:0] hist [0:13];
    logic signed [35:0] acc;
    logic        [3:0]  k;
    logic signed [15:0] out_q;
    logic signed [15:0] coef;
    logic signed [16:0] pre_add;
    logic signed [32:0] prod;
    logic signed [15:0] a_res;
    logic               accept;
    logic               mac_done;

    assign accept       = bus.in_valid && bus.in_ready;
    assign mac_done     = (k == 4'd7);
    assign bus.out_data = out_q;

    always_comb begin
        case (k)
            4'd0:    coef = 16'sd4;
            4'd1:    coef = -16'sd29;
            4'd2:    coef = 16'sd131;
            4'd3:    coef = -16'sd421;
            4'd4:    coef = 16'sd1114;
            4'd5:    coef = -16'sd2785;
            4'd6:    coef = 16'sd10179;
            default: coef = 16'sd0;
        endcase
    end

    // Symmetric taps share one coefficient, so fold the mirrored pair before multiplying.
    assign pre_add = 17'(hist[k]) + 17'(hist[4'd13 - k]);
    assign prod    = 33'(pre_add) * 33'(coef);

`ifdef HB_INTERP_SAT_EN
    logic signed [35:0] acc_shr;
    logic               a_clamp;

    assign acc_shr = acc >>> 14;

    always_comb begin
        a_clamp = 1'b1;
        if (acc_shr > 36'sd32767)
            a_res = 16'sh7fff;
        else if (acc_shr < -36'sd32768)
            a_res = 16'sh8000;
        else begin
            a_res   = acc_shr[15:0];
            a_clamp = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (state == MAC && mac_done && a_clamp)
            sat_flag <= 1'b1;
    end
`else
    // Shift by 14 rather than 15 supplies the x2 interpolation gain.
    assign a_res = acc[29:14];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)        state_nxt = MAC;
            MAC:   if (mac_done)      state_nxt = OUT_A;
            OUT_A: if (bus.out_ready) state_nxt = OUT_B;
            OUT_B: if (bus.out_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:         bus.in_ready  = !reset;
            OUT_A, OUT_B: bus.out_valid = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 14; i++)
                hist[i] <= '0;
            acc   <= '0;
            k     <= '0;
            out_q <= '0;
        end else begin
            if (accept) begin
                hist[0] <= bus.in_data;
                for (int i = 1; i < 14; i++)
                    hist[i] <= hist[i-1];
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                if (mac_done)
                    out_q <= a_res;
                else begin
                    acc <= acc + 36'(prod);
                    k   <= k + 4'd1;
                end
            end else if (state == OUT_A && bus.out_ready) begin
                // Odd phase is the centre tap (0.5 x gain 2): the sample itself.
                out_q <= hist[6];
            end
        end
    end
endmodule
